// File: rtl/replay_pkg.sv
// ============================================================================
//  Module      : replay_pkg
//  Description : Shared types and default constants for the replay controller
//                (FSM state enum, default parameters, statistics counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package replay_pkg;

  // Default configuration of the replay controller
  localparam int N_DEF          = 10;
  localparam int R_DEF          = 4;
  localparam int BO_LOG_MAX_DEF = 4;
  localparam int LL_THRESH_DEF  = 8;

  // Width of each per-source replay statistics counter
  localparam int STAT_W = 16;

  // Replay FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_BACKOFF = 2'd2
  } rpl_state_e;

endpackage : replay_pkg

`default_nettype wire

// File: rtl/rr_arb.sv
// ============================================================================
//  Module      : rr_arb
//  Description : Round-robin arbiter. Grants the first asserted request at or
//                after the priority pointer (wrapping); the pointer moves to
//                granted index + 1 only when adv is high and a grant exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb #(
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [R-1:0] req,
  input  logic         adv,
  output logic [R-1:0] gnt
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found_w;

  // Two passes: indices at/above the pointer first, then the wrapped ones
  always_comb begin
    gnt     = '0;
    found_w = 1'b0;
    ptr_d   = ptr_q;
    for (int i = 0; i < R; i++) begin
      if (!found_w && req[i] && (i >= int'(ptr_q))) begin
        gnt[i]  = 1'b1;
        found_w = 1'b1;
        ptr_d   = PW'((i + 1) % R);
      end
    end
    for (int i = 0; i < R; i++) begin
      if (!found_w && req[i]) begin
        gnt[i]  = 1'b1;
        found_w = 1'b1;
        ptr_d   = PW'((i + 1) % R);
      end
    end
  end

  // Priority pointer moves only on an actual grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (adv && found_w) begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb

`default_nettype wire

// File: rtl/replay_ctrl.sv
// ============================================================================
//  Module      : replay_ctrl
//  Description : Stage-8 replay controller. Issues a replay strobe, flushes for
//                one cycle, then backs off for 2^min(consec,BO_LOG_MAX) cycles.
//                Tracks consecutive replays, flags livelock, arbitrates the
//                charged source round-robin and drives pipe stall requests.
//  Options     : REPLAY_CTRL_STATS_EN - per-source 16-bit saturating replay
//                counters on stat_cnt (tied to 0 when undefined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module replay_ctrl
  import replay_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int R          = R_DEF,
  parameter int BO_LOG_MAX = BO_LOG_MAX_DEF,
  parameter int LL_THRESH  = LL_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s8_vld,
  input  logic              s8_commit,
  input  logic [R-1:0]      rpl_req,
  input  logic [N-1:0]      ext_stall_req,
  output logic              replay_s8_w,
  output logic [N-1:0]      stall_req,
  output logic [R-1:0]      rpl_gnt,
  output logic              busy,
  output logic              livelock_r,
  output logic [R*STAT_W-1:0] stat_cnt
);

  localparam int CW = $clog2(LL_THRESH) + 1;
  localparam int BW = BO_LOG_MAX + 1;
  localparam logic [CW-1:0] LL_C = CW'(LL_THRESH);

  rpl_state_e    state_q;
  logic [CW-1:0] consec_q;
  logic [CW-1:0] consec_d;
  logic [BW-1:0] bo_q;
  logic [BW-1:0] bo_load_w;
  logic          livelock_q;
  logic [R-1:0]  arb_gnt_w;
  logic          idle_w;
  int unsigned   bo_exp_w;

  assign idle_w      = (state_q == ST_IDLE);
  // Outputs are gated by reset so they read quiet while rst_n is low
  assign replay_s8_w = rst_n & idle_w & s8_vld & (|rpl_req);
  assign busy        = rst_n & ~idle_w;
  assign rpl_gnt     = replay_s8_w ? arb_gnt_w : '0;
  assign livelock_r  = livelock_q;

  rr_arb #(
    .R (R)
  ) u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rpl_req),
    .adv   (replay_s8_w),
    .gnt   (arb_gnt_w)
  );

  // Stall pass-through; own stall on stage 0 while busy, last stage never stalls
  always_comb begin
    stall_req      = ext_stall_req;
    stall_req[0]   = ext_stall_req[0] | busy;
    stall_req[N-1] = 1'b0;
  end

  // Consecutive-replay counter: saturating increment wins over commit clear
  always_comb begin
    consec_d = consec_q;
    if (replay_s8_w) begin
      if (consec_q != '1) begin
        consec_d = consec_q + 1'b1;
      end
    end else if (s8_commit) begin
      consec_d = '0;
    end
  end

  // Backoff reload L-1 = 2^min(consec,BO_LOG_MAX)-1 as a run of low ones
  always_comb begin
    bo_exp_w = 32'(consec_q);
    if (bo_exp_w > BO_LOG_MAX) begin
      bo_exp_w = BO_LOG_MAX;
    end
    bo_load_w = '0;
    for (int i = 0; i < BW; i++) begin
      if (i < bo_exp_w) begin
        bo_load_w[i] = 1'b1;
      end
    end
  end

  // Replay FSM with consecutive count, backoff counter and sticky livelock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      consec_q   <= '0;
      bo_q       <= '0;
      livelock_q <= 1'b0;
    end else begin
      consec_q <= consec_d;
      if (consec_d >= LL_C) begin
        livelock_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (replay_s8_w) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // consec_q already holds the post-increment count here
          state_q <= ST_BACKOFF;
          bo_q    <= bo_load_w;
        end
        ST_BACKOFF: begin
          if (bo_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            bo_q <= bo_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REPLAY_CTRL_STATS_EN
  generate
    for (genvar g = 0; g < R; g++) begin : g_stats
      logic [STAT_W-1:0] cnt_q;

      // Saturating per-source replay count
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (rpl_gnt[g] && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q;
    end
  endgenerate
`else
  assign stat_cnt = '0;
`endif

endmodule : replay_ctrl

`default_nettype wire

// File: tb/tb_replay_ctrl.sv
// ============================================================================
//  Module      : tb_replay_ctrl
//  Description : Randomised scoreboard bench for replay_ctrl. The driver runs
//                a reference model of the replay rules and queues one record
//                per expected replay; the monitor pops on every replay strobe
//                and follows the busy window, stalls, livelock and stats.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_replay_ctrl;

  localparam int N      = 10;
  localparam int R      = 4;
  localparam int BO     = 4;
  localparam int LL     = 8;
  localparam int SW     = 16;
  localparam int CMAX   = (1 << ($clog2(LL) + 1)) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s8_vld = 1'b0;
  logic            s8_commit = 1'b0;
  logic [R-1:0]    rpl_req = '0;
  logic [N-1:0]    ext_stall_req = '0;
  logic            replay_s8_w;
  logic [N-1:0]    stall_req;
  logic [R-1:0]    rpl_gnt;
  logic            busy;
  logic            livelock_r;
  logic [R*SW-1:0] stat_cnt;

  replay_ctrl #(
    .N          (N),
    .R          (R),
    .BO_LOG_MAX (BO),
    .LL_THRESH  (LL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s8_vld        (s8_vld),
    .s8_commit     (s8_commit),
    .rpl_req       (rpl_req),
    .ext_stall_req (ext_stall_req),
    .replay_s8_w   (replay_s8_w),
    .stall_req     (stall_req),
    .rpl_gnt       (rpl_gnt),
    .busy          (busy),
    .livelock_r    (livelock_r),
    .stat_cnt      (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R-1:0] gnt;
    int           src;
    int           len;
    bit           ll;
    int           stat;
  } rec_t;

  rec_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_rem    = 0;
  int m_consec = 0;
  int m_ptr    = 0;
  bit m_ll     = 1'b0;
  int m_stat[R];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model for that cycle
  task automatic drive(input bit rst, input bit vld, input bit cmt,
                       input logic [R-1:0] req, input logic [N-1:0] ext);
    rec_t r;
    int   g;
    @(posedge clk);
    #1;
    rst_n = rst; s8_vld = vld; s8_commit = cmt; rpl_req = req; ext_stall_req = ext;
    if (!rst) begin
      m_rem = 0; m_consec = 0; m_ptr = 0; m_ll = 1'b0;
      for (int i = 0; i < R; i++) m_stat[i] = 0;
    end else if (m_rem == 0 && vld && req != '0) begin
      g = -1;
      for (int off = 0; off < R; off++) begin
        if (g < 0 && req[(m_ptr + off) % R]) g = (m_ptr + off) % R;
      end
      m_ptr = (g + 1) % R;
      if (m_consec < CMAX) m_consec++;
      r.len = 1 << ((m_consec < BO) ? m_consec : BO);
      if (m_consec >= LL) m_ll = 1'b1;
      m_stat[g]++;
      r.gnt  = R'(1) << g;
      r.src  = g;
      r.ll   = m_ll;
      r.stat = m_stat[g];
      q.push_back(r);
      m_rem = 1 + r.len;
    end else begin
      if (cmt) m_consec = 0;
      if (m_rem > 0) m_rem--;
    end
  endtask

  // Monitor: sample away from the active edge and check against the queue
  rec_t          cur;
  int            win = 0;
  int            rst_cnt = 0;
  logic [N-1:0]  exp_stall;

  always @(negedge clk) begin
    if (!rst_n) begin
      win = 0;
      rst_cnt++;
      exp_stall = ext_stall_req;
      exp_stall[N-1] = 1'b0;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_replay", 64'(replay_s8_w), 64'(0));
      chk("rst_gnt", 64'(rpl_gnt), 64'(0));
      chk("rst_stall", 64'(stall_req), 64'(exp_stall));
      if (rst_cnt >= 2) begin
        chk("rst_livelock", 64'(livelock_r), 64'(0));
        chk("rst_stats", 64'(stat_cnt), 64'(0));
      end
    end else begin
      rst_cnt = 0;
      exp_stall = ext_stall_req;
      exp_stall[0] = ext_stall_req[0] | (win > 0);
      exp_stall[N-1] = 1'b0;
      chk("stall_req", 64'(stall_req), 64'(exp_stall));
      chk("busy", 64'(busy), 64'(win > 0));
      if (win > 0) begin
        chk("replay_masked", 64'(replay_s8_w), 64'(0));
        if (win == cur.len + 1) begin
          chk("livelock", 64'(livelock_r), 64'(cur.ll));
`ifdef REPLAY_CTRL_STATS_EN
          chk("stat_cnt", 64'(stat_cnt[cur.src*SW +: SW]), 64'(cur.stat));
`else
          chk("stat_cnt_zero", 64'(stat_cnt), 64'(0));
`endif
        end
        win--;
      end else if (replay_s8_w) begin
        if (q.size() == 0) begin
          chk("unexpected_replay", 64'(1), 64'(0));
        end else begin
          cur = q.pop_front();
          chk("rpl_gnt", 64'(rpl_gnt), 64'(cur.gnt));
          win = cur.len + 1;
        end
      end else begin
        chk("gnt_idle", 64'(rpl_gnt), 64'(0));
      end
    end
  end

  function automatic logic [N-1:0] rnd_ext();
    if ($urandom_range(0, 7) == 0) return '1;
    return N'($urandom);
  endfunction

  // Random traffic phase with a given commit probability (percent)
  task automatic phase(input int cycles, input int cmt_pct);
    logic [R-1:0] req;
    for (int c = 0; c < cycles; c++) begin
      req = ($urandom_range(0, 3) == 0) ? '0 : R'($urandom);
      drive(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < cmt_pct, req, rnd_ext());
    end
  endtask

  initial begin
    for (int i = 0; i < R; i++) m_stat[i] = 0;
    repeat (3) drive(1'b0, 1'b0, 1'b0, '0, rnd_ext());

    // Single replay from source 2, then idle to let the window close
    drive(1'b1, 1'b1, 1'b0, 4'b0100, '0);
    repeat (6) drive(1'b1, 1'b0, 1'b1, '0, '0);

    // Full-request fairness across replays separated by commits
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 4'b1111, 10'h3FF);
      repeat (4) drive(1'b1, 1'b0, 1'b1, 4'b0001, 10'h3FF);
    end

    phase(300, 40);  // mostly short backoffs
    phase(400, 0);   // no commits: backoff growth and livelock
    phase(200, 25);  // livelock must stay set across commits

    // Reset in the middle of a backoff window
    while (m_rem == 0) drive(1'b1, 1'b1, 1'b0, 4'b0010, rnd_ext());
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0, rnd_ext());
    repeat (2) drive(1'b0, 1'b1, 1'b1, 4'b1111, rnd_ext());

    phase(300, 30);
    repeat (40) drive(1'b1, 1'b0, 1'b0, '0, rnd_ext());
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_replay_ctrl

`default_nettype wire

// File: doc/replay_ctrl.md
REPLAY_CTRL -- requirements
Module: replay_ctrl

Interface
REQ-001 Parameters SHALL be:
- N, default 10: pipeline depth.
- R, default 4: number of replay sources.
- BO_LOG_MAX, default 4: maximum backoff exponent.
- LL_THRESH, default 8: consecutive-replay livelock threshold.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous active-low reset.
- s8_vld, in, 1: stage-8 instruction valid and advancing this cycle.
- s8_commit, in, 1: stage-8 commit.
- rpl_req, in, R: per-source replay request for the stage-8 instruction.
- ext_stall_req, in, N: external per-stage stall requests.
- replay_s8_w, out, 1: replay strobe to the pipe.
- stall_req, out, N: per-stage stall requests to the pipe.
- rpl_gnt, out, R: one-hot source charged with the replay.
- busy, out, 1: FSM not IDLE.
- livelock_r, out, 1: sticky livelock flag.
- stat_cnt, out, R×16: per-source replay counts.

Function
REQ-003 FSM SHALL have three states, IDLE, FLUSH and BACKOFF, encoded as a 2-bit enum.
REQ-004 In IDLE, replay_s8_w SHALL equal s8_vld & |rpl_req, combinationally, in the same cycle.
REQ-005 IDLE SHALL go to FLUSH on the cycle after replay_s8_w=1.
REQ-006 FLUSH SHALL last exactly 1 cycle, then go to BACKOFF.
REQ-007 BACKOFF SHALL last L = 2^min(consec, BO_LOG_MAX) cycles, then go to IDLE.
REQ-008 consec SHALL be the count of replays since the last s8_commit, evaluated after increment.
REQ-009 In FLUSH and BACKOFF, replay_s8_w SHALL be 0 and rpl_req SHALL be ignored.
REQ-010 stall_req[0] SHALL be 1 in FLUSH and BACKOFF.
REQ-011 stall_req[i] SHALL equal ext_stall_req[i] | (i==0 & busy).
REQ-012 stall_req[N-1] SHALL always be 0, whatever ext_stall_req[N-1] is.
REQ-013 rpl_gnt SHALL be one-hot and round-robin among asserted rpl_req bits.
- It is valid only when replay_s8_w=1 and is 0 otherwise.
- The priority pointer SHALL advance to the granted index +1 (mod R) only on a grant.
REQ-014 consec SHALL be a saturating counter of width clog2(LL_THRESH)+1.
- It increments on each replay_s8_w.
- It clears on s8_commit.
- If both occur in the same cycle, increment wins.
REQ-015 livelock_r SHALL set when consec reaches LL_THRESH and SHALL clear only on reset.
REQ-016 The backoff down-counter SHALL be BO_LOG_MAX+1 bits wide.
- It loads L-1 on entry to BACKOFF.
- BACKOFF exits when it reads 0.
REQ-017 s8_commit and s8_vld & |rpl_req in the same cycle SHALL be treated as a replay; the commit SHALL not clear consec.

Reset
REQ-018 On rst_n=0 at a clk edge, the following SHALL hold:
- state=IDLE.
- consec=0.
- backoff counter=0.
- round-robin pointer=0.
- livelock_r=0.
- stat_cnt all 0.
REQ-019 During reset, replay_s8_w, rpl_gnt and busy SHALL be 0, and stall_req SHALL equal ext_stall_req with bit N-1 forced to 0.
REQ-020 Reset asserted mid-BACKOFF SHALL abort the backoff, and the block SHALL be in IDLE on the following cycle.

Configuration
REQ-021 With REPLAY_CTRL_STATS_EN defined, stat_cnt[r] SHALL be a 16-bit saturating counter, incremented when rpl_gnt[r]=1.
REQ-022 Without REPLAY_CTRL_STATS_EN, stat_cnt SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-023 The FSM state enum, the default parameter constants and the stat count width SHALL live in the shared package replay_pkg.
REQ-024 Round-robin arbitration SHALL be a sub-module rr_arb, parameterised by R, with req, gnt and an advance enable.

Verification
REQ-025 Single replay, defaults:
- Stimulus: s8_vld=1, rpl_req=4'b0100 at cycle t, no prior replays.
- Response: replay_s8_w=1 at t; rpl_gnt=4'b0100; FLUSH at t+1; BACKOFF for 2 cycles (t+2..t+3); IDLE at t+4; stall_req[0]=1 for t+1..t+3.
REQ-026 Round-robin fairness:
- Stimulus: rpl_req=4'b1111 on 4 replays separated by commits.
- Response: rpl_gnt=0001, 0010, 0100, 1000 in order.
REQ-027 Backoff growth:
- Stimulus: 5 consecutive replays with no commit.
- Response: BACKOFF lengths 2, 4, 8, 16, 16 cycles.
REQ-028 Livelock:
- Stimulus: 8 replays with no commit.
- Response: livelock_r=1 after the 8th and remains 1 after subsequent commits.
- Stimulus: 7 replays, then a commit.
- Response: consec=0 and the next BACKOFF lasts 2 cycles.
REQ-029 Request masking and stall pass-through:
- Stimulus: rpl_req=4'b0001 asserted throughout FLUSH/BACKOFF.
- Response: replay_s8_w stays 0.
- Stimulus: ext_stall_req=10'h3FF.
- Response: stall_req=10'h1FF.
REQ-030 Reset and stats:
- Stimulus: rst_n=0 mid-BACKOFF.
- Response: IDLE next cycle with busy=0.
- Stimulus: REPLAY_CTRL_STATS_EN defined, 3 grants to source 1.
- Response: stat_cnt[1]=3.
